// File: rtl/pwm_demodulator.sv
// PWM symbol demodulator: recovers the count of high steps per symbol
// from an asynchronous PWM stream, with edge-based framing lock.
module pwm_demodulator #(
  parameter  int CLKS_PER_STEP = 4,
  parameter  int PWM_STEPS     = 64,
  parameter  int LOCK_LOSS     = 4,
  localparam int SW            = $clog2(PWM_STEPS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pwm_in,
  output logic [SW-1:0] sample,
  output logic          sample_valid,
  output logic          locked,
  output logic          sync_err
);

  localparam int CW  = $clog2(CLKS_PER_STEP);
  localparam int STW = $clog2(PWM_STEPS);
  localparam int MW  = $clog2(LOCK_LOSS + 1);

  localparam logic [CW-1:0]  CLK_LAST  = CW'(CLKS_PER_STEP - 1);
  localparam logic [CW-1:0]  HALF_C    = CW'(CLKS_PER_STEP / 2);
  localparam logic [STW-1:0] STEP_LAST = STW'(PWM_STEPS - 1);
  localparam logic [MW-1:0]  LOSS_C    = MW'(LOCK_LOSS);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t         state_q, state_d;
  logic           sync1_q, sync2_q, sync3_q;
  logic [CW-1:0]  clk_cnt_q, clk_cnt_d;
  logic [STW-1:0] step_cnt_q, step_cnt_d;
  logic [SW-1:0]  acc_q, acc_d;
  logic [MW-1:0]  mis_q, mis_d;
  logic           edge_seen_q, edge_seen_d;
  logic           mis_seen_q, mis_seen_d;
  logic [SW-1:0]  sample_q, sample_d;
  logic           sample_valid_q, sample_valid_d;
  logic           locked_q, locked_d;
  logic           sync_err_q, sync_err_d;

  logic          rise, clk_wrap, sym_end, hit;
  logic          mis_edge, sym_edge, sym_mis;
  logic [SW-1:0] acc_inc;
  logic [MW-1:0] mis_next;

  always_comb begin
    rise     = sync2_q & ~sync3_q;
    clk_wrap = (clk_cnt_q == CLK_LAST);
    sym_end  = clk_wrap && (step_cnt_q == STEP_LAST);
    hit      = (clk_cnt_q == HALF_C) && sync2_q;
    acc_inc  = acc_q + SW'(hit);
    mis_edge = rise && (step_cnt_q != '0)
                    && (step_cnt_q != STEP_LAST);
    sym_edge = edge_seen_q | rise;
    sym_mis  = mis_seen_q | mis_edge;
    // symbols without any edge leave the misalign count alone
    mis_next = sym_mis  ? mis_q + MW'(1) :
               sym_edge ? '0 : mis_q;

    state_d        = state_q;
    clk_cnt_d      = clk_wrap ? '0 : clk_cnt_q + CW'(1);
    step_cnt_d     = step_cnt_q;
    if (clk_wrap)
      step_cnt_d   = (step_cnt_q == STEP_LAST) ? '0
                   : step_cnt_q + STW'(1);
    acc_d          = '0;
    edge_seen_d    = 1'b0;
    mis_seen_d     = 1'b0;
    mis_d          = mis_q;
    sample_d       = sample_q;
    sample_valid_d = 1'b0;
    locked_d       = locked_q;
    sync_err_d     = 1'b0;

    case (state_q)
      HUNT: begin
        // locking cycle is clock 0 of step 0; an edge
        // right after a loss of lock is not used
        if (rise && !sync_err_q) begin
          state_d    = LOCKED;
          locked_d   = 1'b1;
          clk_cnt_d  = CW'(1);
          step_cnt_d = '0;
        end
      end
      LOCKED: begin
        acc_d       = acc_inc;
        edge_seen_d = sym_edge;
        mis_seen_d  = sym_mis;
        if (sym_end) begin
          acc_d          = '0;
          edge_seen_d    = 1'b0;
          mis_seen_d     = 1'b0;
          sample_d       = acc_inc;
          sample_valid_d = 1'b1;
          mis_d          = mis_next;
          if (mis_next == LOSS_C) begin
            state_d    = HUNT;
            locked_d   = 1'b0;
            sync_err_d = 1'b1;
            mis_d      = '0;
          end
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= HUNT;
      sync1_q        <= 1'b0;
      sync2_q        <= 1'b0;
      sync3_q        <= 1'b0;
      clk_cnt_q      <= '0;
      step_cnt_q     <= '0;
      acc_q          <= '0;
      mis_q          <= '0;
      edge_seen_q    <= 1'b0;
      mis_seen_q     <= 1'b0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      locked_q       <= 1'b0;
      sync_err_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      sync1_q        <= pwm_in;
      sync2_q        <= sync1_q;
      sync3_q        <= sync2_q;
      clk_cnt_q      <= clk_cnt_d;
      step_cnt_q     <= step_cnt_d;
      acc_q          <= acc_d;
      mis_q          <= mis_d;
      edge_seen_q    <= edge_seen_d;
      mis_seen_q     <= mis_seen_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
      locked_q       <= locked_d;
      sync_err_q     <= sync_err_d;
    end
  end

  assign sample       = sample_q;
  assign sample_valid = sample_valid_q;
  assign locked       = locked_q;
  assign sync_err     = sync_err_q;

endmodule

// File: tb/tb_pwm_demodulator.sv
// Directed bench for pwm_demodulator at default parameters
// (4 clocks/step, 64 steps/symbol, lock loss after 4 symbols).
module tb_pwm_demodulator;

  localparam int CPS = 4;
  localparam int SYM = 256;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pwm_in = 1'b0;
  logic [6:0] sample;
  logic       sample_valid;
  logic       locked;
  logic       sync_err;

  int checks = 0;
  int errors = 0;

  pwm_demodulator dut (
    .clk          (clk),
    .rst          (rst),
    .pwm_in       (pwm_in),
    .sample       (sample),
    .sample_valid (sample_valid),
    .locked       (locked),
    .sync_err     (sync_err)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   vq[$];
  int   vc[$];
  int   ec[$];
  int   rises = 0;
  int   drops = 0;
  int   rise_cyc = 0;
  logic lk_prev = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (sample_valid) begin
      vq.push_back(int'(sample));
      vc.push_back(cyc);
    end
    if (sync_err) ec.push_back(cyc);
    if (locked && !lk_prev) begin
      rises++;
      rise_cyc = cyc;
    end
    if (!locked && lk_prev) drops++;
    lk_prev = locked;
  end

  task automatic clear_log();
    vq.delete();
    vc.delete();
    ec.delete();
    rises = 0;
    drops = 0;
  endtask

  task automatic drive(input logic v);
    @(posedge clk);
    #1 pwm_in = v;
  endtask

  task automatic sym(input int hi, input int len);
    for (int i = 0; i < len; i++) drive(i < hi * CPS);
  endtask

  task automatic check_vals(input string nm, input int exp_n,
                            input int exp_v[$]);
    checks++;
    if (vq.size() !== exp_n) begin
      errors++;
      $display("FAIL %s count: got %0d expected %0d",
               nm, vq.size(), exp_n);
    end
    for (int i = 0; i < exp_n && i < vq.size(); i++) begin
      checks++;
      if (vq[i] !== exp_v[i]) begin
        errors++;
        $display("FAIL %s sample[%0d]: got %0d expected %0d",
                 nm, i, vq[i], exp_v[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({locked, sample_valid, sync_err} !== 3'b000) begin
      errors++;
      $display("FAIL reset flags: got %b expected 000",
               {locked, sample_valid, sync_err});
    end
    checks++;
    if (sample !== 7'd0) begin
      errors++;
      $display("FAIL reset sample: got %0d expected 0", sample);
    end
    rst = 1'b0;
    clear_log();
  endtask

  task automatic test_lock();
    for (int s = 0; s < 5; s++) sym(37, SYM);
    checks++;
    if (rises !== 1 || locked !== 1'b1) begin
      errors++;
      $display("FAIL lock: got rises=%0d locked=%b expected 1/1",
               rises, locked);
    end
    check_vals("lock", 4, '{37, 37, 37, 37});
    // locking cycle is clock 0, locked rises one cycle later
    checks++;
    if (vc.size() > 0 && vc[0] - rise_cyc !== SYM - 1) begin
      errors++;
      $display("FAIL first_valid delay: got %0d expected %0d",
               vc[0] - rise_cyc, SYM - 1);
    end
    for (int i = 1; i < vc.size(); i++) begin
      checks++;
      if (vc[i] - vc[i-1] !== SYM) begin
        errors++;
        $display("FAIL valid period: got %0d expected %0d",
                 vc[i] - vc[i-1], SYM);
      end
    end
  endtask

  task automatic test_zero_one();
    clear_log();
    sym(0, SYM);
    sym(64, SYM);
    sym(37, SYM);
    sym(37, SYM);
    check_vals("zero_one", 4, '{37, 0, 64, 37});
    checks++;
    if (locked !== 1'b1 || drops !== 0 || ec.size() !== 0) begin
      errors++;
      $display("FAIL zero_one lock: got locked=%b drops=%0d err=%0d expected 1/0/0",
               locked, drops, ec.size());
    end
  endtask

  task automatic test_jitter();
    clear_log();
    sym(37, SYM - 1);
    sym(37, SYM + 1);
    sym(37, SYM);
    sym(37, SYM);
    check_vals("jitter", 4, '{37, 37, 37, 37});
    checks++;
    if (locked !== 1'b1 || drops !== 0 || ec.size() !== 0) begin
      errors++;
      $display("FAIL jitter lock: got locked=%b drops=%0d err=%0d expected 1/0/0",
               locked, drops, ec.size());
    end
  endtask

  task automatic test_phase_shift();
    clear_log();
    for (int i = 0; i < 20 * CPS; i++) drive(1'b0);
    for (int s = 0; s < 7; s++) sym(37, SYM);
    check_vals("phase", 7, '{37, 37, 37, 37, 37, 37, 37});
    checks++;
    if (ec.size() !== 1 || drops !== 1) begin
      errors++;
      $display("FAIL phase sync_err: got pulses=%0d drops=%0d expected 1/1",
               ec.size(), drops);
    end
    checks++;
    if (ec.size() > 0 && vc.size() > 4 && ec[0] !== vc[4]) begin
      errors++;
      $display("FAIL phase err_cycle: got %0d expected %0d",
               ec[0], vc[4]);
    end
    checks++;
    if (locked !== 1'b1 || rises !== 1) begin
      errors++;
      $display("FAIL relock: got locked=%b rises=%0d expected 1/1",
               locked, rises);
    end
    checks++;
    if (vc.size() > 5 && vc[5] - rise_cyc !== SYM - 1) begin
      errors++;
      $display("FAIL relock delay: got %0d expected %0d",
               vc[5] - rise_cyc, SYM - 1);
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 30 * CPS; i++) drive(1'b1);
    checks++;
    if (locked !== 1'b1 || sample !== 7'd37) begin
      errors++;
      $display("FAIL pre_reset: got locked=%b sample=%0d expected 1/37",
               locked, sample);
    end
    @(posedge clk);
    #2 rst = 1'b1;
    pwm_in = 1'b0;
    #1;
    checks++;
    if ({locked, sample_valid, sync_err} !== 3'b000 || sample !== 7'd0) begin
      errors++;
      $display("FAIL async_reset: got flags=%b sample=%0d expected 000/0",
               {locked, sample_valid, sync_err}, sample);
    end
    clear_log();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 100; i++) drive(1'b0);
    for (int s = 0; s < 3; s++) sym(37, SYM);
    check_vals("mid_reset", 2, '{37, 37});
    checks++;
    if (rises !== 1 || (vc.size() > 0 && vc[0] - rise_cyc !== SYM - 1)) begin
      errors++;
      $display("FAIL mid_reset relock: got rises=%0d delay=%0d expected 1/%0d",
               rises, vc.size() > 0 ? vc[0] - rise_cyc : -1, SYM - 1);
    end
  endtask

  task automatic test_const_one();
    rst = 1'b1;
    pwm_in = 1'b1;
    repeat (3) @(negedge clk);
    clear_log();
    rst = 1'b0;
    repeat (800) @(negedge clk);
    check_vals("const_one", 3, '{64, 64, 64});
    checks++;
    if (rises !== 1 || locked !== 1'b1 || ec.size() !== 0) begin
      errors++;
      $display("FAIL const_one lock: got rises=%0d locked=%b err=%0d expected 1/1/0",
               rises, locked, ec.size());
    end
    checks++;
    if (vc.size() > 0 && vc[0] - rise_cyc !== SYM - 1) begin
      errors++;
      $display("FAIL const_one delay: got %0d expected %0d",
               vc[0] - rise_cyc, SYM - 1);
    end
  endtask

  task automatic test_const_zero();
    rst = 1'b1;
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    clear_log();
    rst = 1'b0;
    repeat (600) @(negedge clk);
    checks++;
    if (rises !== 0 || locked !== 1'b0 || vq.size() !== 0) begin
      errors++;
      $display("FAIL const_zero: got rises=%0d locked=%b valids=%0d expected 0/0/0",
               rises, locked, vq.size());
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_zero_one();
    test_jitter();
    test_phase_shift();
    test_mid_reset();
    test_const_one();
    test_const_zero();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
